aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
//  Iterative AES-128 encryption controller. It accepts one plaintext and key per handshake and computes the
//  initial AddRoundKey itself. It then runs an external single-round datapath (SubBytes/ShiftRows/MixColumns/
//  AddRoundKey) for NR consecutive cycles, generating each round key on the fly, and returns the ciphertext
//  over a valid/ready output handshake. It replaces the unrolled round chain in area-constrained builds.
// PARAMETERS
//  NR      10   rounds per block; 10 = AES-128; 1..9 legal only for reduced-round debug
//  KEY_W   128  key/block width; fixed at 128
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    reset: synchronous, active-high
//  in_valid   in   1    plaintext/key offered
//  in_ready   out  1    controller can accept
//  in_data    in   128  plaintext block
//  in_key     in   128  cipher key
//  out_valid  out  1    ciphertext available
//  out_ready  in   1    consumer accepts ciphertext
//  out_data   out  128  ciphertext
//  dp_state   out  128  state presented to the round datapath
//  dp_key     out  128  round key for the current round
//  dp_last    out  1    final round: datapath bypasses MixColumns
//  dp_result  in   128  combinational datapath result for dp_state/dp_key/dp_last
//  busy       out  1    FSM not IDLE
//  round_idx  out  4    current round, 1..NR in ROUND; 0 otherwise
// BEHAVIOUR
//  Reset: FSM=IDLE. state_reg, key_reg, out_data, dp_* all 0. rcon=8'h01. out_valid=0, busy=0, round_idx=0.
//    in_ready=0 while rst is high.
//  in_ready = !rst && (IDLE || (DONE && out_ready)). This lets a new block be accepted in the same cycle the
//    previous one leaves.
//  Accept (in_valid && in_ready):
//    state_reg <= in_data ^ in_key; key_reg <= in_key; rcon <= 8'h01; round <= 1; go to ROUND.
//  ROUND, one round per cycle:
//    nk = key_step(key_reg, rcon).
//    Drive dp_state=state_reg, dp_key=nk, dp_last=(round==NR).
//    At the clock edge: state_reg <= dp_result; key_reg <= nk; rcon <= xtime(rcon) (wraps 80->1b->36).
//    If round==NR, go to DONE; otherwise round <= round+1.
//  DONE: out_valid=1, out_data=state_reg.
//    out_data stays stable while out_valid && !out_ready (backpressure holds indefinitely).
//    On out_ready: go to ROUND if a new block is accepted that cycle, otherwise go to IDLE.
//  Latency: out_valid rises NR cycles after the accept edge.
//  Throughput: one block per NR+1 cycles when back-to-back.
//  in_valid during ROUND is ignored (in_ready=0); the input is not latched.
//  rst mid-operation: the block is discarded, no out_valid is produced, and the next cycle is IDLE with reset values.
//  dp_* hold their last values outside ROUND; dp_last=0 outside ROUND.
// CONFIGURATION
//  AES_SEQ_ABORT_EN defined:
//    Adds input port abort (1 bit).
//    abort=1 in ROUND or DONE: the next state is IDLE, state_reg/key_reg are cleared to 0, and out_valid is never
//      raised for that block.
//    abort has priority over out_ready and over a same-cycle accept.
//    abort in IDLE: no effect.
//  AES_SEQ_ABORT_EN undefined:
//    Port absent. A started block always completes.
// STRUCTURE
//  Package aes_pkg: FSM state enum {IDLE, ROUND, DONE}; AES_BLOCK_W=128; RCON_INIT=8'h01; sbox() function;
//    xtime() function; rot_word() function.
//  Sub-module aes_key_step: combinational; inputs key_reg and rcon, output the next round key
//    (RotWord, SubWord, Rcon XOR, word chain).
//  Top module: FSM, round counter, rcon register, state/key registers, handshake logic.
// TESTING
//  Bench: a reference round-datapath model drives dp_result.
//  1. FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//     -> out 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept.
//     Round 1 dp_key=a0fafe1788542cb123a339392a6c7605; round 10 dp_key=d014f9a8c9ee2589e13f0cc8b6630ca6
//     with dp_last=1.
//  2. FIPS-197 C.1 (key 000102..0f, pt 00112233..ff) issued back-to-back after test 1 with out_ready=1
//     -> accepted in test 1's DONE cycle, out 69c4e0d86a7b0430d8cdb78070b4c55a, 11-cycle spacing.
//  3. Hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and out_data stable, in_ready=0, in_valid ignored.
//     Release -> single transfer.
//  4. Assert rst at round 4 -> next cycle busy=0, round_idx=0, out_valid=0, in_ready=1 after rst drops.
//     A subsequent App.B block is still correct.
//  5. AES_SEQ_ABORT_EN: abort at round 7 -> IDLE next cycle, no out_valid.
//     abort in DONE with out_ready=1 and in_valid=1 -> no transfer, no accept.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, constants and byte helpers for the AES round sequencer
// Purpose: FSM state type, block width, round-constant seed, forward S-box,
//          GF(2^8) doubling and word rotation used by the key schedule.
// Ports:   none (package)
package aes_pkg;

    localparam int         AES_BLOCK_W = 128;
    localparam logic [7:0] RCON_INIT   = 8'h01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    // Forward S-box; entry 0x00 occupies the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] lsb;
        // Entry b sits 8*(255-b) bits above bit 0, and 255-b == ~b for a byte.
        lsb = {~b, 3'b000};
        return SBOX_TABLE[lsb +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - combinational AES-128 next-round-key generator
// Purpose: derives round key r+1 from round key r and the round constant.
// Ports:   i_key      current round key (word 0 in bits 127:96)
//          i_rcon     round constant for the key being produced
//          o_next_key next round key
module aes_key_step
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] i_key,
    input  logic [7:0]             i_rcon,
    output logic [AES_BLOCK_W-1:0] o_next_key
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_sub;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0  = i_key[127:96];
    assign w_w1  = i_key[95:64];
    assign w_w2  = i_key[63:32];
    assign w_w3  = i_key[31:0];

    assign w_rot = rot_word(w_w3);
    assign w_sub = {sbox(w_rot[31:24]) ^ i_rcon, sbox(w_rot[23:16]),
                    sbox(w_rot[15:8]), sbox(w_rot[7:0])};

    // Each new word chains off the previous new word.
    assign w_n0  = w_w0 ^ w_sub;
    assign w_n1  = w_w1 ^ w_n0;
    assign w_n2  = w_w2 ^ w_n1;
    assign w_n3  = w_w3 ^ w_n2;

    assign o_next_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES-128 encryption controller around an external round datapath
// Purpose: accepts plaintext+key, applies the initial AddRoundKey, then steps an
//          external single-round datapath NR times with on-the-fly round keys.
// Option:  AES_SEQ_ABORT_EN adds i_abort, which drops the block in flight.
// Ports:   i_clk/i_rst                       clock, synchronous active-high reset
//          i_in_valid/o_in_ready/i_in_data/i_in_key   block input handshake
//          o_out_valid/i_out_ready/o_out_data         ciphertext output handshake
//          o_dp_state/o_dp_key/o_dp_last/i_dp_result  round datapath interface
//          o_busy, o_round_idx                        status
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int KEY_W = AES_BLOCK_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [KEY_W-1:0] i_in_data,
    input  logic [KEY_W-1:0] i_in_key,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [KEY_W-1:0] o_out_data,
    output logic [KEY_W-1:0] o_dp_state,
    output logic [KEY_W-1:0] o_dp_key,
    output logic             o_dp_last,
    input  logic [KEY_W-1:0] i_dp_result,
    output logic             o_busy,
    output logic [3:0]       o_round_idx
`ifdef AES_SEQ_ABORT_EN
    ,
    input  logic             i_abort
`endif
);

    aes_state_e       r_state;
    logic [KEY_W-1:0] r_state_reg;
    logic [KEY_W-1:0] r_key_reg;
    logic [7:0]       r_rcon;
    logic [3:0]       r_round;
    logic [KEY_W-1:0] r_dp_state;
    logic [KEY_W-1:0] r_dp_key;

    logic [KEY_W-1:0] w_next_key;
    logic             w_in_round;
    logic             w_last;
    logic             w_abort;
    logic             w_in_ready;
    logic             w_accept;

    aes_key_step u_key_step (
        .i_key      (r_key_reg),
        .i_rcon     (r_rcon),
        .o_next_key (w_next_key)
    );

`ifdef AES_SEQ_ABORT_EN
    assign w_abort = i_abort && (r_state != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_in_round = (r_state == ROUND);
    assign w_last     = w_in_round && (r_round == 4'(NR));
    // A new block may enter in the same cycle the finished one leaves.
    assign w_in_ready = !i_rst && !w_abort &&
                        ((r_state == IDLE) || ((r_state == DONE) && i_out_ready));
    assign w_accept   = i_in_valid && w_in_ready;

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = (r_state == DONE) && !w_abort;
    assign o_out_data  = r_state_reg;
    assign o_busy      = (r_state != IDLE);
    assign o_round_idx = r_round;
    // The datapath sees live values while rounds run and the last ones otherwise.
    assign o_dp_state  = w_in_round ? r_state_reg : r_dp_state;
    assign o_dp_key    = w_in_round ? w_next_key  : r_dp_key;
    assign o_dp_last   = w_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_state_reg <= '0;
            r_key_reg   <= '0;
            r_rcon      <= RCON_INIT;
            r_round     <= '0;
            r_dp_state  <= '0;
            r_dp_key    <= '0;
        end else if (w_abort) begin
            r_state     <= IDLE;
            r_state_reg <= '0;
            r_key_reg   <= '0;
            r_round     <= '0;
        end else if (w_accept) begin
            r_state     <= ROUND;
            r_state_reg <= i_in_data ^ i_in_key;
            r_key_reg   <= i_in_key;
            r_rcon      <= RCON_INIT;
            r_round     <= 4'd1;
        end else begin
            case (r_state)
                ROUND: begin
                    r_state_reg <= i_dp_result;
                    r_key_reg   <= w_next_key;
                    r_rcon      <= xtime(r_rcon);
                    r_dp_state  <= r_state_reg;
                    r_dp_key    <= w_next_key;
                    if (w_last) begin
                        r_state <= DONE;
                        r_round <= '0;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - scoreboard testbench for aes_round_sequencer
module tb_aes_round_sequencer;

    localparam int NR = 10;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, dp_last, busy;
    logic [127:0] in_data, in_key, out_data, dp_state, dp_key, dp_result;
    logic [3:0]   round_idx;
`ifdef AES_SEQ_ABORT_EN
    logic         abort;
`endif

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           xfers = 0;
    int           last_rise = 0;
    int           prev_rise = 0;
    logic         rnd_bp = 1'b0;
    logic [127:0] exp_q[$];
    int           acc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_round_sequencer #(.NR(NR)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_key    (in_key),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_dp_state  (dp_state),
        .o_dp_key    (dp_key),
        .o_dp_last   (dp_last),
        .i_dp_result (dp_result),
        .o_busy      (busy),
        .o_round_idx (round_idx)
`ifdef AES_SEQ_ABORT_EN
        ,
        .i_abort     (abort)
`endif
    );

    // ---------------- reference model: GF(2^8) arithmetic from first principles
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box = affine transform of the multiplicative inverse (a^254).
    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        logic [7:0] t = a;
        for (int i = 1; i < 8; i++) begin
            t   = gmul(t, t);
            inv = gmul(inv, t);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_ref(input logic [127:0] st, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   c [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox_ref(st[127-8*i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) b[r+4*k] = a[r + 4*((k+r)%4)];
        for (int k = 0; k < 4; k++) begin
            if (last) begin
                for (int r = 0; r < 4; r++) c[4*k+r] = b[4*k+r];
            end else begin
                c[4*k]   = gmul(b[4*k], 2) ^ gmul(b[4*k+1], 3) ^ b[4*k+2] ^ b[4*k+3];
                c[4*k+1] = b[4*k] ^ gmul(b[4*k+1], 2) ^ gmul(b[4*k+2], 3) ^ b[4*k+3];
                c[4*k+2] = b[4*k] ^ b[4*k+1] ^ gmul(b[4*k+2], 2) ^ gmul(b[4*k+3], 3);
                c[4*k+3] = gmul(b[4*k], 3) ^ b[4*k+1] ^ b[4*k+2] ^ gmul(b[4*k+3], 2);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = c[i] ^ rk[127-8*i -: 8];
        return o;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [4*(NR+1)];
        logic [31:0]  t;
        logic [7:0]   rc = 8'h01;
        logic [127:0] st;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]) ^ rc, sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
                rc = gmul(rc, 2);
            end
            w[i] = w[i-4] ^ t;
        end
        st = pt ^ key;
        for (int r = 1; r <= NR; r++)
            st = round_ref(st, {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}, r == NR);
        return st;
    endfunction

    // External round datapath.
    assign dp_result = round_ref(dp_state, dp_key, dp_last);

    // ---------------- checking helpers
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offers a block from a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [127:0] pt, input logic [127:0] key);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = pt;
        in_key   = key;
        for (int i = 0; i < 60 && !ok; i++) begin
            #2;
            if (in_ready) begin
                ok = 1'b1;
                acc_q.push_back(cyc + 1);
                exp_q.push_back(aes_ref(pt, key));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chkb("accept_timeout", ok, 1'b1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chkb("valid_timeout", out_valid, 1'b1);
    endtask

    // ---------------- monitor: pops the scoreboard on every output transfer
    initial begin : monitor
        logic         prev_v;
        logic [127:0] e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid && !prev_v) begin
                    prev_rise = last_rise;
                    last_rise = cyc;
                    if (acc_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: out_valid rose at cycle %0d, none pending", cyc);
                    end else begin
                        chki("latency", cyc - acc_q.pop_front(), NR);
                    end
                end
                if (out_valid && out_ready) begin
                    xfers++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer: got %h expected none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ciphertext", out_data, e);
                    end
                end
                prev_v = out_valid;
            end
        end
    end

    initial begin : backpressure
        forever begin
            @(negedge clk);
            if (rnd_bp) out_ready = ($urandom_range(3) != 0);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus
    initial begin : stim
        logic [127:0] held;
        int           x0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        in_key    = '0;
`ifdef AES_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        chk("model_appB", aes_ref(B_PT, B_KEY), B_CT);
        chk("model_c1", aes_ref(C_PT, C_KEY), C_CT);

        repeat (3) @(negedge clk);
        chkb("rst_in_ready", in_ready, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_out_valid", out_valid, 1'b0);
        chkb("rst_dp_last", dp_last, 1'b0);
        chki("rst_round_idx", int'(round_idx), 0);
        chk("rst_dp_state", dp_state, '0);
        chk("rst_dp_key", dp_key, '0);
        chk("rst_out_data", out_data, '0);
        rst = 1'b0;
        @(negedge clk);
        chkb("idle_in_ready", in_ready, 1'b1);

        // 1: App.B, round keys and latency
        send(B_PT, B_KEY);
        for (int k = 1; k <= NR; k++) begin
            chki("t1_round_idx", int'(round_idx), k);
            chkb("t1_valid_low", out_valid, 1'b0);
            chkb("t1_dp_last", dp_last, k == NR);
            if (k == 1) chk("t1_rk1", dp_key, B_RK1);
            if (k == NR) chk("t1_rk10", dp_key, B_RK10);
            if (k < NR) @(negedge clk);
        end

        // 2: C.1 offered during round 10, accepted in the DONE cycle
        send(C_PT, C_KEY);
        wait_valid(20);
        chk("t2_out", out_data, C_CT);
        #2;
        chki("t2_spacing", last_rise - prev_rise, NR + 1);

        // 3: backpressure hold
        @(negedge clk);
        out_ready = 1'b0;
        send(rnd128(), rnd128());
        wait_valid(20);
        held = out_data;
        x0   = xfers;
        for (int k = 0; k < 5; k++) begin
            chkb("t3_valid_hold", out_valid, 1'b1);
            chk("t3_data_hold", out_data, held);
            chkb("t3_in_ready", in_ready, 1'b0);
            in_valid = 1'b1;
            in_data  = rnd128();
            in_key   = rnd128();
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chki("t3_single_xfer", xfers - x0, 1);
        chkb("t3_idle", busy, 1'b0);

        // 4: reset at round 4
        send(B_PT, B_KEY);
        repeat (3) @(negedge clk);
        chki("t4_round4", int'(round_idx), 4);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        acc_q.delete();
        chkb("t4_busy", busy, 1'b0);
        chki("t4_round_idx", int'(round_idx), 0);
        chkb("t4_out_valid", out_valid, 1'b0);
        chkb("t4_in_ready_rst", in_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chkb("t4_in_ready", in_ready, 1'b1);
        send(B_PT, B_KEY);
        wait_valid(20);
        chk("t4_out", out_data, B_CT);
        @(negedge clk);

`ifdef AES_SEQ_ABORT_EN
        // 5a: abort in round 7
        send(rnd128(), rnd128());
        repeat (6) @(negedge clk);
        chki("t5_round7", int'(round_idx), 7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        exp_q.delete();
        acc_q.delete();
        chkb("t5_busy", busy, 1'b0);
        chki("t5_round_idx", int'(round_idx), 0);
        repeat (12) @(negedge clk);
        chkb("t5_no_valid", out_valid, 1'b0);
        // 5b: abort in DONE beats out_ready and a same-cycle accept
        x0 = xfers;
        send(rnd128(), rnd128());
        wait_valid(20);
        abort     = 1'b1;
        in_valid  = 1'b1;
        in_data   = rnd128();
        in_key    = rnd128();
        out_ready = 1'b1;
        #2;
        chkb("t5_abort_in_ready", in_ready, 1'b0);
        chkb("t5_abort_valid", out_valid, 1'b0);
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        acc_q.delete();
        chkb("t5_abort_idle", busy, 1'b0);
        chki("t5_abort_xfers", xfers - x0, 0);
        @(negedge clk);
`endif

        // random blocks with random gaps and backpressure
        rnd_bp = 1'b1;
        for (int b = 0; b < 10; b++) begin
            repeat ($urandom_range(2)) @(negedge clk);
            send(rnd128(), rnd128());
        end
        rnd_bp    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
        chki("drain_exp", exp_q.size(), 0);
        chki("drain_acc", acc_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
